vga_box_drawer: RTL and testbench
=================================

# vga_box_drawer

Parametrised pixel-stream generator for the VGA adapter: on a start pulse it rasters a BOX_W × BOX_H rectangle anchored at a latched (x, y). It emits one pixel per clock as x_out/y_out/colour_out with a plot strobe. Three modes are supported: filled piece, outline-only pointer, and erase to background. It sits between the game-board controller and the VGA adapter's write port, and supersedes the fixed-count pointer/player draw controller.

## Interface
- BOX_W, 4, rectangle width in pixels (≥1)
- BOX_H, 4, rectangle height in pixels (≥1)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width
- BG_COLOUR, 0, colour used in erase mode
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- start  in  1  request a draw; sampled only when idle (see Timing)
- mode  in  2  0 = piece (filled), 1 = pointer (outline), 2 = erase (filled, BG_COLOUR), 3 = treated as piece
- x_in  in  X_W  anchor x (top-left), latched on accepted start
- y_in  in  Y_W  anchor y, latched on accepted start
- colour_in  in  COLOUR_W  draw colour, latched on accepted start
- x_out  out  X_W  current pixel x
- y_out  out  Y_W  current pixel y
- colour_out  out  COLOUR_W  current pixel colour
- plot  out  1  write strobe for current pixel
- busy  out  1  high while rastering
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: busy=0, plot=0. On start=1, the block latches x_in, y_in, colour_in and mode, clears dx and dy, and moves to DRAW.
- DRAW: busy=1. Each cycle presents pixel (x_base+dx, y_base+dy).
  - dx increments each cycle.
  - When dx reaches BOX_W-1, dx wraps to 0 and dy increments.
  - After the cycle presenting (BOX_W-1, BOX_H-1), the block moves to DONE.
- DONE: done=1, busy=0, plot=0 for exactly one cycle, then IDLE.
  - start=1 during DONE is accepted exactly as in IDLE; the next state is DRAW, giving back-to-back draws with no idle gap.
- plot in DRAW:
  - Piece and erase modes: plot=1 for every pixel.
  - Pointer mode: plot=1 only on border pixels (dx==0, dx==BOX_W-1, dy==0 or dy==BOX_H-1), otherwise 0. Interior cycles are still spent, so latency is independent of mode.
  - When BOX_W or BOX_H is ≤2, every pixel is a border pixel.
- colour_out = BG_COLOUR in erase mode, otherwise the latched colour.
- Coordinate arithmetic: x_base+dx is computed modulo 2^X_W and y_base+dy modulo 2^Y_W (truncating wrap, no clipping).
- start while in DRAW is ignored. Latched values never change mid-draw.

## Timing
- All outputs are registered.
- Reset values: x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0, state IDLE.
- Start accepted at edge N: first pixel is valid after edge N+1, last pixel after edge N+BOX_W·BOX_H, done high after edge N+BOX_W·BOX_H+1.
- Exactly BOX_W·BOX_H DRAW cycles per request, in raster order (row-major, left to right).
- resetn low mid-draw: at the next edge all outputs return to reset values. No done pulse and no further plot for the aborted draw.
- Simultaneous resetn low and start: reset wins.

## Structure
- Shared package vga_draw_pkg holds:
  - mode encodings MODE_PIECE, MODE_POINTER, MODE_ERASE;
  - state encodings ST_IDLE, ST_DRAW, ST_DONE.
- Sub-module raster_counter (params W, H) provides dx/dy, a wrap-aware increment and the last and border flags. The top level holds the FSM, latches and output registers.

## Test plan
- Piece draw: BOX 4×4, start with (10,20), colour 3'b100, mode 0 → 16 consecutive plot=1 cycles covering x 10..13, y 20..23 row-major, colour 3'b100; done one cycle later; busy low in the done cycle.
- Pointer draw: same anchor, mode 1 → 16 DRAW cycles, 12 with plot=1; plot=0 at (11,21), (12,21), (11,22), (12,22); done at the same cycle as the piece draw.
- Erase draw: mode 2, colour_in 3'b111, BG_COLOUR 0 → all 16 pixels plotted with colour_out=0.
- Ignored start and back-to-back draws:
  - start pulsed mid-DRAW → no restart and no latch change.
  - start held high during the DONE cycle → new draw begins the next cycle with the new anchor.
- X wrap: x_in=254, BOX_W=4 → x_out sequence 254, 255, 0, 1 per row.
- Reset mid-draw: resetn low at the 5th pixel → next cycle all outputs 0, no done pulse. A subsequent start draws the full 16 pixels normally.

Source files
------------

// File: rtl/vga_draw_pkg.sv
// Shared encodings for the VGA box drawer:
// draw modes and raster FSM states.
package vga_draw_pkg;

  typedef enum logic [1:0] {
    MODE_PIECE   = 2'd0,
    MODE_POINTER = 2'd1,
    MODE_ERASE   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vga_box_drawer_raster_counter.sv
// Row-major dx/dy walker over a W x H box,
// with last-pixel and border flags for the current position.
module raster_counter
  import vga_draw_pkg::*;
#(
  parameter int W = 4,
  parameter int H = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic [((W > 1) ? $clog2(W) : 1)-1:0] dx,
  output logic [((H > 1) ? $clog2(H) : 1)-1:0] dy,
  output logic last,
  output logic border
);

  localparam int DXW = (W > 1) ? $clog2(W) : 1;
  localparam int DYW = (H > 1) ? $clog2(H) : 1;
  localparam logic [DXW-1:0] XMAX = DXW'(W - 1);
  localparam logic [DYW-1:0] YMAX = DYW'(H - 1);

  logic x_end;
  logic y_end;

  assign x_end  = (dx == XMAX);
  assign y_end  = (dy == YMAX);
  assign last   = x_end && y_end;
  // Boxes of width or height <= 2 have no interior, so this is always 1 there.
  assign border = (dx == '0) || x_end || (dy == '0) || y_end;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (clr) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (x_end) begin
        dx <= '0;
        dy <= y_end ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_box_drawer.sv
// Rasters a BOX_W x BOX_H rectangle at a latched anchor,
// one registered pixel per clock, in piece/pointer/erase modes.
module vga_box_drawer
  import vga_draw_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  state_e state_q;
  state_e state_d;
  logic accept;
  logic drawing;

  logic [X_W-1:0]      x_base;
  logic [Y_W-1:0]      y_base;
  logic [COLOUR_W-1:0] colour_q;
  logic [1:0]          mode_q;

  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;
  logic last;
  logic border;

  assign drawing = (state_q == ST_DRAW);

  raster_counter #(
    .W(BOX_W),
    .H(BOX_H)
  ) u_cnt (
    .clk(clk),
    .resetn(resetn),
    .clr(accept),
    .en(drawing),
    .dx(dx),
    .dy(dy),
    .last(last),
    .border(border)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A start here chains straight into the next draw.
        accept  = start;
        state_d = start ? ST_DRAW : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_base   <= '0;
      y_base   <= '0;
      colour_q <= '0;
      mode_q   <= '0;
    end else if (accept) begin
      x_base   <= x_in;
      y_base   <= y_in;
      colour_q <= colour_in;
      mode_q   <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= drawing;
      done <= (state_q == ST_DONE);
      plot <= drawing &&
              ((mode_q != MODE_POINTER) || border);
      if (drawing) begin
        x_out      <= x_base + X_W'(dx);
        y_out      <= y_base + Y_W'(dy);
        colour_out <= (mode_q == MODE_ERASE) ? BG_COLOUR : colour_q;
      end
    end
  end

endmodule

// File: tb/tb_vga_box_drawer.sv
// Directed bench for vga_box_drawer: piece, pointer, erase,
// ignored/chained starts, x wrap and reset abort.
module tb_vga_box_drawer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] mode;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int plots;

  vga_box_drawer #(
    .BOX_W(4),
    .BOX_H(4),
    .X_W(8),
    .Y_W(7),
    .COLOUR_W(3),
    .BG_COLOUR(3'd0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .mode(mode),
    .x_in(x_in),
    .y_in(y_in),
    .colour_in(colour_in),
    .x_out(x_out),
    .y_out(y_out),
    .colour_out(colour_out),
    .plot(plot),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] c, input logic [1:0] m);
    x_in = x;
    y_in = y;
    colour_in = c;
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walk the 16 pixels; poke >= 0 pulses a junk start before that pixel.
  task automatic pixels(input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] c, input logic [1:0] m,
                        input int poke);
    logic [7:0] ex;
    logic [6:0] ey;
    logic       ep;
    plots = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == poke) begin
        start = 1'b1;
        x_in = 8'd99;
        y_in = 7'd77;
        colour_in = 3'd1;
        mode = 2'd2;
      end
      tick();
      start = 1'b0;
      ex = x + 8'(i % 4);
      ey = y + 7'(i / 4);
      ep = (m != 2'd1) || (i % 4 == 0) || (i % 4 == 3) ||
           (i / 4 == 0) || (i / 4 == 3);
      if (ep) plots++;
      chk("x_out", 32'(x_out), 32'(ex));
      chk("y_out", 32'(y_out), 32'(ey));
      chk("colour_out", 32'(colour_out),
          (m == 2'd2) ? 32'd0 : 32'(c));
      chk("plot", 32'(plot), 32'(ep));
      chk("busy", 32'(busy), 32'd1);
      chk("done_in_draw", 32'(done), 32'd0);
    end
  endtask

  task automatic expect_done();
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("plot_at_done", 32'(plot), 32'd0);
    tick();
    chk("done_clears", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    x_in = '0;
    y_in = '0;
    colour_in = '0;
    tick();
    tick();
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_colour", 32'(colour_out), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Reset wins over a simultaneous start.
    kick(8'd10, 7'd20, 3'd4, 2'd0);
    resetn = 1'b1;
    tick();
    chk("rst_beats_start", 32'(busy), 32'd0);
    tick();
    chk("rst_beats_start_plot", 32'(plot), 32'd0);

    kick(8'd10, 7'd20, 3'b100, 2'd0);
    pixels(8'd10, 7'd20, 3'b100, 2'd0, -1);
    chk("piece_plots", 32'(plots), 32'd16);
    expect_done();

    kick(8'd10, 7'd20, 3'b100, 2'd1);
    pixels(8'd10, 7'd20, 3'b100, 2'd1, -1);
    chk("pointer_plots", 32'(plots), 32'd12);
    expect_done();

    kick(8'd10, 7'd20, 3'b111, 2'd2);
    pixels(8'd10, 7'd20, 3'b111, 2'd2, -1);
    expect_done();

    // Mode 3 behaves as a filled piece.
    kick(8'd40, 7'd50, 3'b010, 2'd3);
    pixels(8'd40, 7'd50, 3'b010, 2'd0, -1);
    expect_done();

    // Mid-draw start ignored, then start held through DONE chains.
    kick(8'd10, 7'd20, 3'b101, 2'd0);
    pixels(8'd10, 7'd20, 3'b101, 2'd0, 4);
    x_in = 8'd30;
    y_in = 7'd40;
    colour_in = 3'b011;
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("chain_done", 32'(done), 32'd1);
    chk("chain_busy", 32'(busy), 32'd0);
    pixels(8'd30, 7'd40, 3'b011, 2'd0, -1);
    expect_done();

    kick(8'd254, 7'd5, 3'b001, 2'd0);
    pixels(8'd254, 7'd5, 3'b001, 2'd0, -1);
    expect_done();

    // Abort after the 5th pixel.
    kick(8'd10, 7'd20, 3'b110, 2'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_pre_x", 32'(x_out), 32'd10);
    chk("abort_pre_y", 32'(y_out), 32'd21);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("abort_x", 32'(x_out), 32'd0);
    chk("abort_y", 32'(y_out), 32'd0);
    chk("abort_colour", 32'(colour_out), 32'd0);
    chk("abort_plot", 32'(plot), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_quiet", 32'({done, plot, busy}), 32'd0);
    end

    kick(8'd10, 7'd20, 3'b100, 2'd0);
    pixels(8'd10, 7'd20, 3'b100, 2'd0, -1);
    chk("after_abort_plots", 32'(plots), 32'd16);
    expect_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
